// File: rtl/localization_pkg.sv
// Shared constants and types for the localization path.
// PI_Q / TWO_PI_Q are pi and 2*pi in Q2.13. The field constants locate the
// magnitude and phase inside a 32-bit polar word from the CORDIC stage.
package localization_pkg;

  localparam int PI_Q     = 25736;
  localparam int TWO_PI_Q = 51472;

  localparam int MAG_LSB = 0;
  localparam int MAG_MSB = 15;
  localparam int PH_LSB  = 16;
  localparam int PH_MSB  = 31;

  typedef logic signed [15:0] phase_t;
  typedef logic [15:0]        mag_t;

endpackage

// File: rtl/phase_wrap_sub.sv
// Wrapped phase difference ph_ch - ph_ref in Q2.13. The result always lies
// in (-PI_Q, PI_Q]. Purely combinational.
//   ph_ref   : reference phase (channel 0)
//   ph_ch    : phase of the channel being compared
//   diff_out : wrapped difference
module phase_wrap_sub
  import localization_pkg::*;
(
  input  phase_t ph_ref,
  input  phase_t ph_ch,
  output phase_t diff_out
);

  localparam logic signed [16:0] PI17     = 17'(PI_Q);
  localparam logic signed [16:0] TWO_PI17 = 17'(TWO_PI_Q);

  logic signed [16:0] d_raw;
  logic signed [16:0] d_wrap;

  always_comb begin
    d_raw  = 17'(ph_ch) - 17'(ph_ref);
    d_wrap = d_raw;
    if (d_raw > PI17) begin
      d_wrap = d_raw - TWO_PI17;
    end else if (d_raw <= -PI17) begin
      d_wrap = d_raw + TWO_PI17;
    end
  end

  assign diff_out = d_wrap[15:0];

endmodule

// File: rtl/peak_phase_extract.sv
// Per-frame peak search on the channel-0 magnitude within [BIN_LO, BIN_HI].
// At frame end the block reports the peak bin, its magnitude, and the
// wrapped phase of each channel relative to channel 0.
//   clk_in, rst_in  : clock and synchronous active-high reset
//   data_in[c]      : polar word per channel (mag [15:0], phase [31:16])
//   valid_in        : one beat = one FFT bin, all channels
//   peak_bin_out    : bin index of the frame peak
//   peak_mag_out    : channel-0 magnitude at the peak
//   phase_diff_out  : element k = phase(ch k+1) - phase(ch 0), wrapped
//   valid_out       : one-cycle pulse marking new outputs
module peak_phase_extract
  import localization_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FFT_SIZE   = 1024,
  parameter int BIN_LO     = 4,
  parameter int BIN_HI     = 511
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [DATA_WIDTH-1:0]       data_in [CHANNELS],
  input  logic                        valid_in,
  output logic [$clog2(FFT_SIZE)-1:0] peak_bin_out,
  output logic [15:0]                 peak_mag_out,
  output logic signed [15:0]          phase_diff_out [CHANNELS-1],
  output logic                        valid_out
);

  localparam int BW = $clog2(FFT_SIZE);
  localparam logic [BW-1:0] LO_B   = BW'(BIN_LO);
  localparam logic [BW-1:0] HI_B   = BW'(BIN_HI);
  localparam logic [BW-1:0] LAST_B = BW'(FFT_SIZE - 1);

  mag_t   mag0;
  phase_t ph_in [CHANNELS];
  logic   load_best;

  logic [BW-1:0] bin_cnt_q, bin_cnt_d;
  mag_t          best_mag_q, best_mag_d;
  logic [BW-1:0] best_bin_q, best_bin_d;
  phase_t        best_ph_q [CHANNELS];
  phase_t        best_ph_d [CHANNELS];
  logic          done_q, done_d;

  // Snapshot of the search result, so the next frame may start overwriting
  // the best registers while the output stage still works on this frame.
  mag_t          snap_mag_q, snap_mag_d;
  logic [BW-1:0] snap_bin_q, snap_bin_d;
  phase_t        snap_ph_q [CHANNELS];
  phase_t        snap_ph_d [CHANNELS];
  logic          snap_vld_q, snap_vld_d;

  logic [BW-1:0] peak_bin_q, peak_bin_d;
  mag_t          peak_mag_q, peak_mag_d;
  phase_t        diff_q [CHANNELS-1];
  phase_t        diff_d [CHANNELS-1];
  logic          vld_q, vld_d;

  phase_t        wrap_diff [CHANNELS-1];

  always_comb begin
    mag0 = data_in[0][MAG_MSB:MAG_LSB];
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ph_in[c] = phase_t'(data_in[c][PH_MSB:PH_LSB]);
    end
  end

  // Bin BIN_LO loads unconditionally, which restarts the search for each frame.
  assign load_best = valid_in &&
                     ((bin_cnt_q == LO_B) ||
                      ((bin_cnt_q > LO_B) && (bin_cnt_q <= HI_B) && (mag0 > best_mag_q)));

  always_comb begin
    bin_cnt_d  = bin_cnt_q;
    best_mag_d = best_mag_q;
    best_bin_d = best_bin_q;
    best_ph_d  = best_ph_q;
    done_d     = 1'b0;
    if (valid_in) begin
      bin_cnt_d = bin_cnt_q + BW'(1);
      done_d    = (bin_cnt_q == LAST_B);
    end
    if (load_best) begin
      best_mag_d = mag0;
      best_bin_d = bin_cnt_q;
      best_ph_d  = ph_in;
    end
  end

  always_comb begin
    snap_mag_d = snap_mag_q;
    snap_bin_d = snap_bin_q;
    snap_ph_d  = snap_ph_q;
    snap_vld_d = done_q;
    if (done_q) begin
      snap_mag_d = best_mag_q;
      snap_bin_d = best_bin_q;
      snap_ph_d  = best_ph_q;
    end
  end

  for (genvar k = 0; k < CHANNELS - 1; k++) begin : g_wrap
    phase_wrap_sub u_wrap (
      .ph_ref  (snap_ph_q[0]),
      .ph_ch   (snap_ph_q[k+1]),
      .diff_out(wrap_diff[k])
    );
  end

  always_comb begin
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;
    diff_d     = diff_q;
    vld_d      = snap_vld_q;
    if (snap_vld_q) begin
      peak_bin_d = snap_bin_q;
      peak_mag_d = snap_mag_q;
      diff_d     = wrap_diff;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bin_cnt_q  <= '0;
      best_mag_q <= '0;
      best_bin_q <= '0;
      best_ph_q  <= '{default: '0};
      done_q     <= 1'b0;
      snap_mag_q <= '0;
      snap_bin_q <= '0;
      snap_ph_q  <= '{default: '0};
      snap_vld_q <= 1'b0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
      diff_q     <= '{default: '0};
      vld_q      <= 1'b0;
    end else begin
      bin_cnt_q  <= bin_cnt_d;
      best_mag_q <= best_mag_d;
      best_bin_q <= best_bin_d;
      best_ph_q  <= best_ph_d;
      done_q     <= done_d;
      snap_mag_q <= snap_mag_d;
      snap_bin_q <= snap_bin_d;
      snap_ph_q  <= snap_ph_d;
      snap_vld_q <= snap_vld_d;
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
      diff_q     <= diff_d;
      vld_q      <= vld_d;
    end
  end

  assign peak_bin_out   = peak_bin_q;
  assign peak_mag_out   = peak_mag_q;
  assign phase_diff_out = diff_q;
  assign valid_out      = vld_q;

endmodule

// File: tb/tb_peak_phase_extract.sv
// Bench for peak_phase_extract with FFT_SIZE=16, band [2,10], 4 channels.
// A frame-level model picks the expected peak and wrapped phase differences
// from each completed frame. One process compares every output on every cycle
// against the model. Directed scenarios also check hand-computed literals.
module tb_peak_phase_extract;

  localparam int CH  = 4;
  localparam int DW  = 32;
  localparam int FS  = 16;
  localparam int LO  = 2;
  localparam int HI  = 10;
  localparam int PIQ = 25736;
  localparam int TPQ = 51472;

  logic              clk = 1'b0;
  logic              rst_in;
  logic [DW-1:0]     data_in [CH];
  logic              valid_in;
  logic [3:0]        peak_bin_out;
  logic [15:0]       peak_mag_out;
  logic signed [15:0] phase_diff_out [CH-1];
  logic              valid_out;

  peak_phase_extract #(
    .CHANNELS  (CH),
    .DATA_WIDTH(DW),
    .FFT_SIZE  (FS),
    .BIN_LO    (LO),
    .BIN_HI    (HI)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .peak_bin_out  (peak_bin_out),
    .peak_mag_out  (peak_mag_out),
    .phase_diff_out(phase_diff_out),
    .valid_out     (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned      due;
    logic [3:0]       bin;
    logic [15:0]      mag;
    logic [2:0][15:0] diff;
  } exp_t;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  bin;
    logic [15:0] mag;
    logic [15:0] d0;
  } pulse_t;

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  bit          rst_sampled = 1'b0;
  bit          run_cmp = 1'b0;

  exp_t   exp_q [$];
  exp_t   held = '0;
  pulse_t plog [$];

  // frame under construction
  logic [15:0] f_mag [FS][CH];
  logic [15:0] f_ph  [FS][CH];
  // model's view of the beats actually delivered in the current frame
  int          m_mag [FS];
  int          m_ph  [FS][CH];
  int          m_bin = 0;
  int unsigned last_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model_frame(input int unsigned due);
    exp_t e;
    int   best;
    int   bm;
    int   d;
    best = LO;
    bm   = m_mag[LO];
    for (int b = LO + 1; b <= HI; b++) begin
      if (m_mag[b] > bm) begin
        bm   = m_mag[b];
        best = b;
      end
    end
    e.due = due;
    e.bin = 4'(best);
    e.mag = 16'(bm);
    for (int k = 0; k < CH - 1; k++) begin
      d = m_ph[best][k+1] - m_ph[best][0];
      if (d > PIQ) d = d - TPQ;
      else if (d <= -PIQ) d = d + TPQ;
      e.diff[k] = 16'(d);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_sampled = rst_in;
  end

  always @(negedge clk) begin
    bit exp_now;
    if (run_cmp) begin
      if (rst_sampled) begin
        exp_q.delete();
        held = '0;
      end
      exp_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (exp_now) held = exp_q.pop_front();
      chk("valid_out", int'(valid_out), int'(exp_now));
      chk("peak_bin_out", int'(peak_bin_out), int'(held.bin));
      chk("peak_mag_out", int'(peak_mag_out), int'(held.mag));
      for (int k = 0; k < CH - 1; k++) begin
        chk($sformatf("phase_diff_out[%0d]", k), int'(phase_diff_out[k]),
            int'($signed(held.diff[k])));
      end
      if (valid_out === 1'b1) begin
        plog.push_back('{cyc: cyc, bin: peak_bin_out, mag: peak_mag_out,
                         d0: phase_diff_out[0]});
      end
    end
  end

  task automatic base_frame();
    for (int b = 0; b < FS; b++) begin
      for (int c = 0; c < CH; c++) begin
        f_mag[b][c] = 16'd100;
        f_ph[b][c]  = 16'(b * 50 + c * 300);
      end
    end
  endtask

  task automatic send_beat(input int b);
    for (int c = 0; c < CH; c++) begin
      data_in[c] = {f_ph[b][c], f_mag[b][c]};
      m_ph[m_bin][c] = int'($signed(f_ph[b][c]));
    end
    m_mag[m_bin] = int'(f_mag[b][0]);
    valid_in = 1'b1;
    if (m_bin == FS - 1) begin
      last_cyc = cyc;
      exp_q.push_back(model_frame(cyc + 3));
    end
    m_bin = (m_bin + 1) % FS;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle_cycle();
    valid_in = 1'b0;
    for (int c = 0; c < CH; c++) data_in[c] = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit gaps, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) idle_cycle();
      end
      send_beat(b);
    end
  endtask

  task automatic do_reset(input int ncyc);
    valid_in = 1'b0;
    rst_in   = 1'b1;
    m_bin    = 0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst_in = 1'b0;
  endtask

  // fixed drain window: long enough for the pulse, and any extra pulse is caught
  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic expect_one(input string name, input int bin, input int mag, input int d0);
    chk({name, " pulses"}, plog.size(), 1);
    if (plog.size() >= 1) begin
      chk({name, " latency"}, int'(plog[0].cyc), int'(last_cyc + 3));
      chk({name, " bin"}, int'(plog[0].bin), bin);
      chk({name, " mag"}, int'(plog[0].mag), mag);
      chk({name, " diff0"}, int'($signed(plog[0].d0)), d0);
    end
    plog.delete();
  endtask

  initial begin
    rst_in   = 1'b1;
    valid_in = 1'b0;
    for (int c = 0; c < CH; c++) data_in[c] = '0;
    @(posedge clk);
    #1;
    run_cmp = 1'b1;
    do_reset(2);

    @(negedge clk);
    chk("reset bin", int'(peak_bin_out), 0);
    chk("reset mag", int'(peak_mag_out), 0);
    chk("reset valid", int'(valid_out), 0);
    @(posedge clk);
    #1;

    // single peak
    base_frame();
    f_mag[7][0] = 16'd5000;
    f_ph[7][0]  = 16'h0000;
    f_ph[7][1]  = 16'h1000;
    send_frame(1'b0, FS);
    drain();
    expect_one("single", 7, 5000, 4096);

    // wrap-around, both directions
    base_frame();
    f_mag[6][0] = 16'd7000;
    f_ph[6][0]  = 16'(-24000);
    f_ph[6][1]  = 16'(24000);
    send_frame(1'b0, FS);
    drain();
    expect_one("wrap_pos", 6, 7000, -3472);

    base_frame();
    f_mag[6][0] = 16'd7000;
    f_ph[6][0]  = 16'(24000);
    f_ph[6][1]  = 16'(-24000);
    send_frame(1'b0, FS);
    drain();
    expect_one("wrap_neg", 6, 7000, 3472);

    // band limits and tie: out-of-band giants ignored, earlier tied bin kept
    base_frame();
    f_mag[0][0]  = 16'd60000;
    f_mag[11][0] = 16'd65535;
    f_mag[3][0]  = 16'd2000;
    f_mag[8][0]  = 16'd2000;
    f_ph[3][0]   = 16'd10;
    f_ph[3][1]   = 16'd30;
    send_frame(1'b0, FS);
    drain();
    expect_one("tie", 3, 2000, 20);

    // last in-band bin is eligible
    base_frame();
    f_mag[10][0] = 16'd3000;
    f_ph[10][0]  = 16'd0;
    f_ph[10][1]  = 16'(-500);
    send_frame(1'b0, FS);
    drain();
    expect_one("hi_edge", 10, 3000, -500);

    // all-zero frame reports BIN_LO
    for (int b = 0; b < FS; b++) begin
      for (int c = 0; c < CH; c++) begin
        f_mag[b][c] = '0;
        f_ph[b][c]  = '0;
      end
    end
    send_frame(1'b0, FS);
    drain();
    expect_one("zero", LO, 0, 0);

    // gaps in valid_in
    base_frame();
    f_mag[7][0] = 16'd5000;
    f_ph[7][0]  = 16'h0000;
    f_ph[7][1]  = 16'h1000;
    send_frame(1'b1, FS);
    drain();
    expect_one("gaps", 7, 5000, 4096);

    // reset mid-frame: aborted frame's large peak must not leak
    base_frame();
    f_mag[7][0] = 16'd5000;
    send_frame(1'b0, 9);
    do_reset(1);
    @(negedge clk);
    chk("midrst mag", int'(peak_mag_out), 0);
    chk("midrst bin", int'(peak_bin_out), 0);
    @(posedge clk);
    #1;
    chk("midrst pulses", plog.size(), 0);
    base_frame();
    f_mag[4][0] = 16'd3000;
    f_ph[4][0]  = 16'd100;
    f_ph[4][1]  = 16'd400;
    send_frame(1'b0, FS);
    drain();
    expect_one("after_rst", 4, 3000, 300);

    // back-to-back continuous frames
    base_frame();
    f_mag[5][0] = 16'd4000;
    f_ph[5][0]  = 16'd1000;
    f_ph[5][1]  = 16'(-2000);
    send_frame(1'b0, FS);
    base_frame();
    f_mag[9][0] = 16'd4500;
    f_ph[9][0]  = 16'(-100);
    f_ph[9][1]  = 16'd200;
    send_frame(1'b0, FS);
    drain();
    chk("b2b pulses", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("b2b spacing", int'(plog[1].cyc - plog[0].cyc), 16);
      chk("b2b A bin", int'(plog[0].bin), 5);
      chk("b2b A mag", int'(plog[0].mag), 4000);
      chk("b2b A diff0", int'($signed(plog[0].d0)), -3000);
      chk("b2b B bin", int'(plog[1].bin), 9);
      chk("b2b B diff0", int'($signed(plog[1].d0)), 300);
    end
    plog.delete();

    chk("pending expectations", exp_q.size(), 0);
    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
